// File: rtl/ram_loader_pkg.sv
// Shared types and helpers for the RAM stream loader.
package ram_loader_pkg;

   // Loader sequencing states
   typedef enum logic [2:0] {
      IDLE,
      FILL,
      WRITE,
      VERIFY,
      CHECK,
      DONE
   } state_t;

   // Default word width and the matching bytes-per-word
   localparam int DEF_DW = 32;
   localparam int NB     = DEF_DW / 8;

   // Widest word the sum helper handles; callers truncate back to their DW
   localparam int MAX_DW = 1024;

   // Word sum; modulo-2^DW wrap comes from the caller's truncating cast
   function automatic logic [MAX_DW-1:0] sum_add(input logic [MAX_DW-1:0] a,
                                                 input logic [MAX_DW-1:0] b);
      return a + b;
   endfunction

endpackage

// File: rtl/ram_stream_packer.sv
// Byte-to-word packer: little-endian byte lanes, byte counter, word-complete flag.
module ram_stream_packer
   import ram_loader_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          inclock,
   input  logic          inaclr_a,
   input  logic          clr,
   input  logic          take,
   input  logic [7:0]    s_data,
   output logic [DW-1:0] word,
   output logic          word_ready
);

   localparam int NB = DW / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   logic [CW-1:0] byte_cnt;

   // High in the cycle the last byte of a word is being accepted
   assign word_ready = take && (byte_cnt == CW'(NB - 1));

   // Drop each accepted byte into lane byte_cnt; wrap the counter after the last lane
   always_ff @(posedge inclock or posedge inaclr_a) begin
      if (inaclr_a) begin
         byte_cnt <= '0;
         word     <= '0;
      end else if (clr) begin
         byte_cnt <= '0;
      end else if (take) begin
         word[8*byte_cnt +: 8] <= s_data;
         byte_cnt              <= word_ready ? '0 : byte_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/ram_stream_loader.sv
// Streams bytes into consecutive RAM words, then reads the region back and
// compares a running word sum to flag a corrupted load.
module ram_stream_loader
   import ram_loader_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 11
) (
   input  logic          inclock,
   input  logic          inaclr_a,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   word_cnt,
   input  logic          s_valid,
   input  logic [7:0]    s_data,
   output logic          s_ready,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_data,
   output logic          ram_en,
   output logic          ram_we,
   input  logic [DW-1:0] ram_q,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [DW-1:0] checksum
);

   state_t        state;
   logic [AW-1:0] base_q;
   logic [AW:0]   cnt_q;
   logic [AW:0]   rem;
   logic [AW:0]   rd_left;
   logic [DW-1:0] rd_sum;
   logic          rd_vld;
   logic [DW-1:0] pk_word;
   logic          pk_ready;
   logic          take;
   logic          clr;

   assign take = s_valid && s_ready;
   assign clr  = (state == IDLE) && start;

   ram_stream_packer #(.DW(DW)) u_packer (
      .inclock    (inclock),
      .inaclr_a   (inaclr_a),
      .clr        (clr),
      .take       (take),
      .s_data     (s_data),
      .word       (pk_word),
      .word_ready (pk_ready)
   );

   // The packer's word register is only complete (and only written) during WRITE
   assign ram_data = pk_word;

   // Sequencer with registered outputs; ram_addr doubles as the write and read pointer
   always_ff @(posedge inclock or posedge inaclr_a) begin
      if (inaclr_a) begin
         state    <= IDLE;
         base_q   <= '0;
         cnt_q    <= '0;
         rem      <= '0;
         rd_left  <= '0;
         rd_sum   <= '0;
         rd_vld   <= 1'b0;
         s_ready  <= 1'b0;
         ram_addr <= '0;
         ram_en   <= 1'b0;
         ram_we   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         checksum <= '0;
      end else begin
         done   <= 1'b0;
         // Read data lands one cycle after its address; accumulate it then
         rd_vld <= ram_en && !ram_we;
         if (rd_vld)
            rd_sum <= DW'(sum_add(MAX_DW'(rd_sum), MAX_DW'(ram_q)));

         case (state)
            IDLE: begin
               if (start) begin
                  base_q   <= base_addr;
                  cnt_q    <= word_cnt;
                  rem      <= word_cnt;
                  ram_addr <= base_addr;
                  checksum <= '0;
                  rd_sum   <= '0;
                  error    <= 1'b0;
                  busy     <= 1'b1;
                  if (word_cnt == '0) begin
                     state <= DONE;
                  end else begin
                     state   <= FILL;
                     s_ready <= 1'b1;
                  end
               end
            end

            FILL: begin
               // Last byte of the word accepted: one write bubble, no byte taken
               if (pk_ready) begin
                  s_ready <= 1'b0;
                  ram_en  <= 1'b1;
                  ram_we  <= 1'b1;
                  state   <= WRITE;
               end
            end

            WRITE: begin
               checksum <= DW'(sum_add(MAX_DW'(checksum), MAX_DW'(pk_word)));
               rem      <= rem - (AW+1)'(1);
               if (rem == (AW+1)'(1)) begin
                  // Keep ram_en high and restart at base for back-to-back reads
                  state    <= VERIFY;
                  ram_we   <= 1'b0;
                  ram_addr <= base_q;
                  rd_left  <= cnt_q;
               end else begin
                  state    <= FILL;
                  ram_en   <= 1'b0;
                  ram_we   <= 1'b0;
                  s_ready  <= 1'b1;
                  ram_addr <= ram_addr + AW'(1);
               end
            end

            VERIFY: begin
               // rd_left counts addresses still to present, including the current one;
               // at zero the cycle is spent absorbing the final read word
               if (rd_left > (AW+1)'(1)) begin
                  ram_addr <= ram_addr + AW'(1);
                  rd_left  <= rd_left - (AW+1)'(1);
               end else if (rd_left == (AW+1)'(1)) begin
                  ram_en  <= 1'b0;
                  rd_left <= '0;
               end else begin
                  state <= CHECK;
               end
            end

            CHECK: begin
               if (rd_sum != checksum)
                  error <= 1'b1;
               state <= DONE;
            end

            DONE: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
